// File: rtl/fifo_pkg.sv
// Shared helpers for the flip-flop FIFO: pointer/level sizing, pointer wrap
// without modulo arithmetic, and the status-flag bundle.
package fifo_pkg;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
   } fifo_flags_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Increment with explicit wrap so non-power-of-2 depths need no modulo.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/flip_flop_fifo_with_level.sv
// Single-clock flip-flop FIFO of arbitrary depth with registered fill level,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module flip_flop_fifo_with_level
   import fifo_pkg::*;
#(
   parameter int unsigned width                         = 8,
   parameter int unsigned depth                         = 5,
   parameter int unsigned almost_full_level             = depth - 1,
   parameter int unsigned almost_empty_level            = 1,
   parameter bit          allow_push_when_full_with_pop = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [width-1:0]              write_data,
   input  logic                          err_clear,
   output logic [width-1:0]              read_data,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic [level_width(depth)-1:0] level,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned PtrW = ptr_width(depth);
   localparam int unsigned LvlW = level_width(depth);

   if (depth < 2 || almost_full_level < 1 || almost_full_level > depth ||
       almost_empty_level > depth - 1) begin : g_param_check
      $error("flip_flop_fifo_with_level: illegal depth/threshold parameters");
   end

   logic [width-1:0] storage_q [depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]  level_q, level_d;
   fifo_flags_t      flags_q, flags_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             push_ok, pop_ok;

   // Acceptance, next pointers/level, and flags pre-decoded from the next level.
   always_comb begin
      push_ok     = 1'b0;
      pop_ok      = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      flags_d     = flags_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      pop_ok  = pop & ~flags_q.empty;
      push_ok = push & (~flags_q.full | (allow_push_when_full_with_pop & pop));

      if (push_ok) wr_ptr_d = PtrW'(next_ptr(32'(wr_ptr_q), depth));
      if (pop_ok)  rd_ptr_d = PtrW'(next_ptr(32'(rd_ptr_q), depth));

      if (push_ok && !pop_ok)      level_d = level_q + LvlW'(1);
      else if (pop_ok && !push_ok) level_d = level_q - LvlW'(1);

      flags_d.empty        = (level_d == LvlW'(0));
      flags_d.full         = (level_d == LvlW'(depth));
      flags_d.almost_empty = (level_d <= LvlW'(almost_empty_level));
      flags_d.almost_full  = (level_d >= LvlW'(almost_full_level));

      // A new error in the same cycle as err_clear keeps the flag set.
      overflow_d  = (push & ~push_ok) | (overflow_q  & ~err_clear);
      underflow_d = (pop  & ~pop_ok)  | (underflow_q & ~err_clear);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         flags_q     <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         flags_q     <= flags_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Data array is intentionally left unreset; validity is tracked by level.
   always_ff @(posedge clk) begin
      if (push_ok) storage_q[wr_ptr_q] <= write_data;
   end

   assign read_data    = storage_q[rd_ptr_q];
   assign level        = level_q;
   assign empty        = flags_q.empty;
   assign full         = flags_q.full;
   assign almost_empty = flags_q.almost_empty;
   assign almost_full  = flags_q.almost_full;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_flip_flop_fifo_with_level.sv
// Bench for flip_flop_fifo_with_level: three instances (depth 5 allow=1,
// depth 5 allow=0, depth 7 thresholds 2/5) checked every cycle against queue models.
module tb_flip_flop_fifo_with_level;

   localparam int unsigned N = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       push [N];
   logic       pop  [N];
   logic       clr  [N];
   logic [7:0] wd   [N];
   logic [7:0] rd   [N];
   logic       emp  [N];
   logic       ful  [N];
   logic       aem  [N];
   logic       afl  [N];
   logic       ovf  [N];
   logic       udf  [N];
   logic [2:0] lvl  [N];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   function automatic int dep(input int i);
      return (i == 2) ? 7 : 5;
   endfunction
   function automatic int af_lvl(input int i);
      return (i == 2) ? 5 : 4;
   endfunction
   function automatic int ae_lvl(input int i);
      return (i == 2) ? 2 : 1;
   endfunction
   function automatic bit allow(input int i);
      return (i != 1);
   endfunction

   flip_flop_fifo_with_level #(.width(8), .depth(5), .almost_full_level(4),
      .almost_empty_level(1), .allow_push_when_full_with_pop(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .push(push[0]), .pop(pop[0]), .write_data(wd[0]),
      .err_clear(clr[0]), .read_data(rd[0]), .empty(emp[0]), .full(ful[0]),
      .almost_empty(aem[0]), .almost_full(afl[0]), .level(lvl[0]),
      .overflow(ovf[0]), .underflow(udf[0]));

   flip_flop_fifo_with_level #(.width(8), .depth(5), .almost_full_level(4),
      .almost_empty_level(1), .allow_push_when_full_with_pop(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .push(push[1]), .pop(pop[1]), .write_data(wd[1]),
      .err_clear(clr[1]), .read_data(rd[1]), .empty(emp[1]), .full(ful[1]),
      .almost_empty(aem[1]), .almost_full(afl[1]), .level(lvl[1]),
      .overflow(ovf[1]), .underflow(udf[1]));

   flip_flop_fifo_with_level #(.width(8), .depth(7), .almost_full_level(5),
      .almost_empty_level(2), .allow_push_when_full_with_pop(1'b1)) u_dut2 (
      .clk(clk), .rst(rst), .push(push[2]), .pop(pop[2]), .write_data(wd[2]),
      .err_clear(clr[2]), .read_data(rd[2]), .empty(emp[2]), .full(ful[2]),
      .almost_empty(aem[2]), .almost_full(afl[2]), .level(lvl[2]),
      .overflow(ovf[2]), .underflow(udf[2]));

   task automatic chk(input string nm, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: a plain queue per instance plus sticky error bits.
   logic [7:0] mq [N][$];
   bit         movf [N];
   bit         mudf [N];
   int         m_sz;
   bit         m_pk, m_pp;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            mq[i].delete();
            movf[i] = 1'b0;
            mudf[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            m_sz = mq[i].size();
            m_pk = push[i] && ((m_sz < dep(i)) || (allow(i) && pop[i]));
            m_pp = pop[i] && (m_sz > 0);
            if (m_pp) void'(mq[i].pop_front());
            if (m_pk) mq[i].push_back(wd[i]);
            movf[i] = (push[i] && !m_pk) || (movf[i] && !clr[i]);
            mudf[i] = (pop[i] && !m_pp) || (mudf[i] && !clr[i]);
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0) chk($sformatf("i%0d.read_data", i), int'(rd[i]), int'(mq[i][0]));
            chk($sformatf("i%0d.level", i), int'(lvl[i]), mq[i].size());
            chk($sformatf("i%0d.empty", i), int'(emp[i]), int'(mq[i].size() == 0));
            chk($sformatf("i%0d.full", i), int'(ful[i]), int'(mq[i].size() == dep(i)));
            chk($sformatf("i%0d.almost_empty", i), int'(aem[i]), int'(mq[i].size() <= ae_lvl(i)));
            chk($sformatf("i%0d.almost_full", i), int'(afl[i]), int'(mq[i].size() >= af_lvl(i)));
            chk($sformatf("i%0d.overflow", i), int'(ovf[i]), int'(movf[i]));
            chk($sformatf("i%0d.underflow", i), int'(udf[i]), int'(mudf[i]));
         end
      end
   end

   task automatic idle_all();
      for (int i = 0; i < N; i++) begin
         push[i] = 1'b0;
         pop[i]  = 1'b0;
         clr[i]  = 1'b0;
         wd[i]   = 8'h00;
      end
   endtask

   // One clock of activity on instance i; returns 1 time unit after the edge.
   task automatic step(input int i, input bit p, input bit q, input logic [7:0] d, input bit c);
      idle_all();
      push[i] = p;
      pop[i]  = q;
      wd[i]   = d;
      clr[i]  = c;
      @(posedge clk);
      #1;
      idle_all();
   endtask

   logic [7:0] exp_d [5];

   initial begin
      idle_all();
      repeat (3) @(posedge clk);
      #1;
      chk("reset.level", int'(lvl[0]), 0);
      chk("reset.empty", int'(emp[0]), 1);
      chk("reset.almost_empty", int'(aem[0]), 1);
      chk("reset.full", int'(ful[0]), 0);
      chk("reset.almost_full", int'(afl[0]), 0);
      chk("reset.overflow", int'(ovf[0]), 0);
      chk("reset.underflow", int'(udf[0]), 0);
      rst = 1'b1;
      chk_en = 1'b1;

      // Fill then drain, depth 5.
      for (int k = 0; k < 5; k++) begin
         step(0, 1'b1, 1'b0, 8'(k * 17), 1'b0);
         chk("fill.level", int'(lvl[0]), k + 1);
         chk("fill.almost_full", int'(afl[0]), int'(k + 1 >= 4));
         chk("fill.full", int'(ful[0]), int'(k == 4));
      end
      for (int k = 0; k < 5; k++) begin
         chk("drain.read_data", int'(rd[0]), k * 17);
         step(0, 1'b0, 1'b1, 8'h00, 1'b0);
         chk("drain.level", int'(lvl[0]), 4 - k);
         chk("drain.almost_empty", int'(aem[0]), int'(4 - k <= 1));
      end
      chk("drain.empty", int'(emp[0]), 1);

      // Wrap-around: pointers move past the last slot.
      for (int k = 1; k <= 3; k++) step(0, 1'b1, 1'b0, 8'(k), 1'b0);
      for (int k = 1; k <= 3; k++) begin
         chk("wrap.pre_read_data", int'(rd[0]), k);
         step(0, 1'b0, 1'b1, 8'h00, 1'b0);
      end
      for (int k = 0; k < 5; k++) step(0, 1'b1, 1'b0, 8'(8'h50 + k), 1'b0);
      chk("wrap.full", int'(ful[0]), 1);
      chk("wrap.level", int'(lvl[0]), 5);

      // Full with simultaneous push+pop, allow = 1.
      step(0, 1'b1, 1'b1, 8'h99, 1'b0);
      chk("fullpp_allow.level", int'(lvl[0]), 5);
      chk("fullpp_allow.overflow", int'(ovf[0]), 0);
      exp_d = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h99};
      for (int k = 0; k < 5; k++) begin
         chk("fullpp_allow.read_data", int'(rd[0]), int'(exp_d[k]));
         step(0, 1'b0, 1'b1, 8'h00, 1'b0);
      end

      // Full with simultaneous push+pop, allow = 0.
      for (int k = 0; k < 5; k++) step(1, 1'b1, 1'b0, 8'(8'h60 + k), 1'b0);
      step(1, 1'b1, 1'b1, 8'hEE, 1'b0);
      chk("fullpp_block.level", int'(lvl[1]), 4);
      chk("fullpp_block.overflow", int'(ovf[1]), 1);
      for (int k = 1; k <= 4; k++) begin
         chk("fullpp_block.read_data", int'(rd[1]), 8'h60 + k);
         step(1, 1'b0, 1'b1, 8'h00, 1'b0);
      end
      step(1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("ovf_clear", int'(ovf[1]), 0);

      // Sticky error behaviour.
      step(0, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("udf.set", int'(udf[0]), 1);
      chk("udf.level", int'(lvl[0]), 0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("udf.clear", int'(udf[0]), 0);
      step(0, 1'b0, 1'b1, 8'h00, 1'b1);
      chk("udf.set_wins", int'(udf[0]), 1);
      step(0, 1'b0, 1'b0, 8'h00, 1'b1);
      step(0, 1'b1, 1'b1, 8'h77, 1'b0);
      chk("nobypass.underflow", int'(udf[0]), 1);
      chk("nobypass.level", int'(lvl[0]), 1);
      chk("nobypass.read_data", int'(rd[0]), 8'h77);
      step(0, 1'b0, 1'b1, 8'h00, 1'b1);

      // Asynchronous reset mid-stream at level 3.
      for (int k = 1; k <= 3; k++) step(0, 1'b1, 1'b0, 8'(8'hA0 + k), 1'b0);
      chk("rst_mid.pre_level", int'(lvl[0]), 3);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid.level", int'(lvl[0]), 0);
      chk("rst_mid.empty", int'(emp[0]), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      step(0, 1'b1, 1'b0, 8'hA5, 1'b0);
      chk("rst_mid.first_push", int'(rd[0]), 8'hA5);
      chk("rst_mid.post_level", int'(lvl[0]), 1);

      // Randomised traffic on the depth-7 instance, biased to visit full and empty.
      for (int c = 0; c < 1000; c++) begin
         int pbias;
         pbias = ((c / 150) % 2 == 0) ? 75 : 25;
         step(2, ($urandom_range(0, 99) < pbias), ($urandom_range(0, 99) >= pbias),
              8'($urandom), ($urandom_range(0, 19) == 0));
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flip_flop_fifo_with_level.md
# flip_flop_fifo_with_level

Parametrised flip-flop FIFO, successor to the counter-based FIFO. Adds:
- arbitrary (non-power-of-2) depth;
- a registered fill-level output;
- almost_full / almost_empty thresholds;
- sticky overflow/underflow error flags;
- a compile-time switch for push-while-full-with-pop.

It sits between a producer and a consumer inside one clock domain. It is the buffer used by the single-cycle CPU's memory and I/O paths.

## Interface
- width, 8: data bits per entry
- depth, 5: number of entries, ≥ 2, any integer
- almost_full_level, depth - 1: almost_full asserts when level ≥ this; range 1..depth
- almost_empty_level, 1: almost_empty asserts when level ≤ this; range 0..depth-1
- allow_push_when_full_with_pop, 1: 1 = push accepted when full if pop is asserted in the same cycle
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- push  in  1  write request
- pop  in  1  read request
- write_data  in  width  data to write
- err_clear  in  1  synchronous clear of sticky error flags
- read_data  out  width  head entry, show-ahead
- empty  out  1  level == 0
- full  out  1  level == depth
- almost_empty  out  1  level ≤ almost_empty_level
- almost_full  out  1  level ≥ almost_full_level
- level  out  $clog2(depth+1)  current occupancy
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- Acceptance rules:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | (allow_push_when_full_with_pop & pop)).
- Storage is a flip-flop array of depth entries. wr_ptr and rd_ptr count 0..depth-1 and wrap from depth-1 to 0; they never use a modulo by a non-power of 2.
- On push_ok: storage[wr_ptr] <= write_data, and wr_ptr advances.
- On pop_ok: rd_ptr advances.
- level next = level + push_ok - pop_ok. Level never exceeds depth and never underflows.
- Flag decoding:
  - empty, full, almost_empty and almost_full are pure compares of the registered level, so they are glitch-free after the clock edge.
  - With allow_push_when_full_with_pop = 0, full blocks push regardless of pop.
- Push on empty with simultaneous pop: there is no bypass. The push is accepted, the pop is rejected, and underflow is set.
- Error flags:
  - overflow is set on push & ~push_ok.
  - underflow is set on pop & empty.
  - Both hold until err_clear or reset. If err_clear coincides with a new error, the set wins.
- read_data = storage[rd_ptr]. It is don't-care while empty.
- Storage is not reset; only pointers, level and flags are.

## Timing
- Written data becomes visible on read_data 1 cycle after push (when the FIFO was empty).
- Pop takes effect at the edge; the next entry appears on read_data in the same cycle the pointer updates.
- All outputs are registered state or combinational decodes of registered state only. No combinational path exists from push/pop to any output.
- Reset values: level = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, wr_ptr = rd_ptr = 0.
- Reset asserted mid-operation clears the FIFO immediately (asynchronously). The first push after release is accepted on the first rising edge with rst = 1.
- Sustained push+pop with 0 < level < depth keeps level constant, giving throughput of 1 entry/cycle.

## Structure
- Package fifo_pkg holds:
  - function ptr_width(depth) = $clog2(depth) (minimum 1);
  - function level_width(depth) = $clog2(depth + 1);
  - function next_ptr(ptr, depth), which wraps to 0 at depth-1.
- No sub-module. A single module of about 150–250 lines. Parameter legality is checked by an elaboration-time assertion.

## Test plan
- Fill then drain, depth = 5: push 0x00, 0x11, 0x22, 0x33, 0x44 -> level 1..5, full after the 5th, almost_full at level 4. Then pop 5 -> read_data 0x00..0x44 in order, empty, almost_empty at level 1 and 0.
- Wrap-around: 3 pushes, 3 pops, then 5 pushes -> pointers wrap past 4. FIFO order is preserved and full = 1 with level 5.
- Full with push+pop: with allow = 1 -> level stays 5, data accepted, no overflow. With allow = 0 -> push rejected, overflow = 1, level drops to 4.
- Errors: pop on empty -> underflow = 1, level 0. err_clear -> 0 next cycle. err_clear together with pop on empty -> underflow stays 1.
- Reset mid-stream at level 3 with rst low for 2 cycles -> level 0 and empty = 1 without waiting for a clock edge. The next push of 0xA5 appears on read_data 1 cycle later.
- Randomized run, depth = 7 and thresholds 2/5, 1000 cycles compared against a queue model: read_data, level and all flags match every cycle.
